// File: rtl/spram_master.sv
// Single-port RAM initiator: valid/ready command channel in, credit-gated read
// response FIFO out, plus a sweep engine that fills every address with one value.
//   state   | meaning
//   S_IDLE  | accepting commands, clr_start sampled here
//   S_CLEAR | writing clr_value to addresses 0..DEPTH-1, one per cycle
module spram_master #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 64,
    parameter int RD_LAT     = 1,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    input  logic                  clr_start,
    input  logic [DATA_WIDTH-1:0] clr_value,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + RD_LAT + 2) + 1;

    logic [0:0]            state;
    logic [ADDR_WIDTH:0]   clr_cnt;
    logic [RD_LAT:0]       rd_pipe;
    logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         in_flight;
    logic [CW-1:0]         used;
    logic                  cmd_fire;
    logic                  push;
    logic                  pop;

    // Every outstanding read owns a FIFO slot, so the FIFO can never overflow.
    always_comb begin
        in_flight = '0;
        for (int i = 0; i <= RD_LAT; i++) begin
            in_flight = in_flight + CW'(rd_pipe[i]);
        end
    end

    assign used      = fifo_count + in_flight;
    assign cmd_ready = rst_n && (state == S_IDLE) && !clr_start && (used < CW'(RSP_DEPTH));
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign push      = rd_pipe[RD_LAT];
    assign rsp_valid = (fifo_count != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_rdata = rsp_valid ? fifo_mem[rd_ptr] : '0;
    assign busy      = (state == S_CLEAR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            clr_cnt  <= '0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_data <= '0;
        end else begin
            ram_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (clr_start) begin
                        // First fill write goes out on the entry edge; ram_data then holds the fill value.
                        state    <= S_CLEAR;
                        ram_we   <= 1'b1;
                        ram_addr <= '0;
                        ram_data <= clr_value;
                        clr_cnt  <= (ADDR_WIDTH + 1)'(1);
                    end else if (cmd_fire) begin
                        ram_we   <= cmd_we;
                        ram_addr <= cmd_addr;
                        if (cmd_we) begin
                            ram_data <= cmd_wdata;
                        end
                    end
                end
                S_CLEAR: begin
                    if (clr_cnt == (ADDR_WIDTH + 1)'(DEPTH)) begin
                        state <= S_IDLE;
                    end else begin
                        ram_we   <= 1'b1;
                        ram_addr <= clr_cnt[ADDR_WIDTH-1:0];
                        clr_cnt  <= clr_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe <= {rd_pipe[RD_LAT-1:0], cmd_fire && !cmd_we};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= ram_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(RSP_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(RSP_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (pop && !push) begin
                fifo_count <= fifo_count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spram_master.sv
// Bench for spram_master: behavioural RAM, reference memory, and a response
// scoreboard that predicts read data at command acceptance.
module tb_spram_master;

    localparam int AW        = 6;
    localparam int DW        = 8;
    localparam int DEPTH     = 64;
    localparam int RD_LAT    = 1;
    localparam int RSP_DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          clr_start = 1'b0;
    logic [DW-1:0] clr_value = '0;
    logic          busy;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic          ram_we;
    logic [DW-1:0] ram_q;

    always #5 clk = ~clk;

    spram_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .clr_start(clr_start), .clr_value(clr_value), .busy(busy),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_q(ram_q)
    );

    // Single-port RAM, one clock of read latency
    logic [DW-1:0] ram_mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_data;
        ram_q <= ram_mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int pop_cnt = 0;
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q [$];

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t vecs [12];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s got=timeout exp=event", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts and ends one time unit after a posedge; leaves cmd_valid asserted.
    task automatic do_cmd(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [DW-1:0] exp_rd, output int acc_cyc);
        int n = 0;
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            n++;
            if (n > 200) begin
                fail("cmd_accept");
                cmd_valid = 1'b0;
                acc_cyc = -1;
                step();
                return;
            end
        end
        if (we) ref_mem[a] = d;
        else exp_q.push_back(exp_rd);
        step();
        acc_cyc = cyc;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        int c;
        do_cmd(1'b0, a, '0, ref_mem[a], c);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int c;
        do_cmd(1'b1, a, d, '0, c);
    endtask

    task automatic drain();
        int n = 0;
        cmd_valid = 1'b0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) fail("drain");
        step();
    endtask

    task automatic run_clear(input logic [DW-1:0] v, input bit with_cmd);
        int k = 0, bad = 0, rdy = 0, n = 0;
        clr_start = 1'b1; clr_value = v;
        if (with_cmd) begin
            cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 6'd5; cmd_wdata = 8'h77;
        end
        @(negedge clk);
        check("clr_start_cmd_ready", cmd_ready, 0);
        step();
        clr_start = 1'b0;
        clr_value = ~v;
        forever begin
            @(negedge clk);
            if (!busy || n > 100) break;
            n++;
            if (!(ram_we && ram_addr == k && ram_data == v)) bad++;
            if (cmd_ready) rdy++;
            clr_start = (k == 10);
            k++;
        end
        clr_start = 1'b0;
        check("clr_cycles", k, DEPTH);
        check("clr_sweep_bad", bad, 0);
        check("clr_cmd_blocked", rdy, 0);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = v;
        if (with_cmd) begin
            check("clr_cmd_after", cmd_ready, 1);
            if (cmd_ready) ref_mem[5] = 8'h77;
        end
        step();
        cmd_valid = 1'b0;
        check("post_clr_we", ram_we, int'(with_cmd));
        check("post_clr_busy", busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, n, consec, pc0, rdy_cnt, diffs;
        logic [DW-1:0] head;

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        fork
            forever begin
                @(negedge clk);
                if (rst_n && rsp_valid && rsp_ready) begin
                    pop_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL rsp_unexpected got=%0h exp=none", rsp_rdata);
                    end else begin
                        check("rsp_rdata", rsp_rdata, exp_q.pop_front());
                    end
                end
            end
        join_none

        // Reset values
        repeat (3) step();
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_data", ram_data, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        rst_n = 1'b1;
        step();
        check("idle_cmd_ready", cmd_ready, 1);

        // Table-driven command vectors, issued back to back
        vecs[0]  = '{1'b1, 6'd0,  8'h01, 8'h00};
        vecs[1]  = '{1'b1, 6'd1,  8'h02, 8'h00};
        vecs[2]  = '{1'b1, 6'd2,  8'h03, 8'h00};
        vecs[3]  = '{1'b0, 6'd0,  8'h00, 8'h01};
        vecs[4]  = '{1'b0, 6'd1,  8'h00, 8'h02};
        vecs[5]  = '{1'b0, 6'd2,  8'h00, 8'h03};
        vecs[6]  = '{1'b1, 6'd63, 8'hFF, 8'h00};
        vecs[7]  = '{1'b1, 6'd32, 8'h80, 8'h00};
        vecs[8]  = '{1'b0, 6'd63, 8'h00, 8'hFF};
        vecs[9]  = '{1'b0, 6'd32, 8'h00, 8'h80};
        vecs[10] = '{1'b1, 6'd0,  8'h5E, 8'h00};
        vecs[11] = '{1'b0, 6'd0,  8'h00, 8'h5E};
        for (int i = 0; i < 12; i++) begin
            do_cmd(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp, a0);
            check("vec_ram_we", ram_we, vecs[i].we);
            check("vec_ram_addr", ram_addr, vecs[i].addr);
            if (vecs[i].we) check("vec_ram_data", ram_data, vecs[i].wdata);
        end
        cmd_valid = 1'b0;
        step();
        check("idle_ram_we", ram_we, 0);
        check("idle_ram_addr_hold", ram_addr, 0);
        check("idle_ram_data_hold", ram_data, 8'h5E);
        drain();

        // First-response latency with an empty FIFO
        rd(6'd2);
        a0 = cyc;
        cmd_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 20);
        check("rd_latency", cyc - a0, RD_LAT + 1);
        drain();

        // Backpressure: four reads fill the credits, the fifth stalls
        pc0 = pop_cnt;
        rsp_ready = 1'b0;
        rd(6'd0); rd(6'd1); rd(6'd2); rd(6'd63);
        cmd_we = 1'b0; cmd_addr = 6'd32; cmd_valid = 1'b1;
        rdy_cnt = 0; diffs = 0;
        @(negedge clk);
        head = rsp_rdata;
        check("bp_rsp_valid", rsp_valid, 1);
        check("bp_head", head, 8'h5E);
        repeat (6) begin
            if (cmd_ready) rdy_cnt++;
            if (rsp_rdata !== head) diffs++;
            @(negedge clk);
        end
        check("bp_cmd_ready", rdy_cnt, 0);
        check("bp_rdata_stable", diffs, 0);
        step();
        rsp_ready = 1'b1;
        rd(6'd32); rd(6'd0);
        drain();
        check("bp_all_returned", pop_cnt - pc0, 6);

        // Clear sweep, then read back the last address
        run_clear(8'hA5, 1'b0);
        rd(6'd63);
        drain();

        // Clear wins over a simultaneous write, which is taken once the sweep ends
        run_clear(8'h3C, 1'b1);
        rd(6'd5); rd(6'd6);
        drain();

        // Reset partway through a clear: last write issued is address 19
        clr_start = 1'b1; clr_value = 8'h5A;
        step();
        clr_start = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ram_we && ram_addr == 6'd19) && n < 100);
        if (n >= 100) fail("clr_reach_19");
        rst_n = 1'b0;
        step();
        check("abort_ram_we", ram_we, 0);
        check("abort_busy", busy, 0);
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_cmd_ready", cmd_ready, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) ref_mem[i] = 8'h5A;
        step();
        rd(6'd19); rd(6'd20); rd(6'd5); rd(6'd0); rd(6'd63);
        drain();

        // Streaming reads with rsp_ready held high
        for (int i = 0; i < 16; i++) wr(AW'(i), DW'(i * 7 + 3));
        cmd_valid = 1'b0;
        step();
        consec = 0;
        fork
            begin
                int c;
                for (int i = 0; i < 16; i++) begin
                    do_cmd(1'b0, AW'(i), '0, ref_mem[i], c);
                    if (i == 0) a0 = c;
                    if (i == 15) a1 = c;
                end
                cmd_valid = 1'b0;
            end
            begin
                int m = 0;
                do begin
                    @(negedge clk);
                    m++;
                end while (!rsp_valid && m < 50);
                consec = rsp_valid ? 1 : 0;
                repeat (15) begin
                    @(negedge clk);
                    if (rsp_valid) consec++;
                end
            end
        join
        check("stream_accept_span", a1 - a0, 15);
        check("stream_consec_rsp", consec, 16);
        drain();
        check("end_rsp_valid", rsp_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
